// File: rtl/cnn_icb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cnn_icb_arbiter
// Purpose  : Two-master/one-slave ICB arbiter (E203 data path + CNN master)
//            with round-robin grant, stall lock and in-order response routing.
// Revision : 1.0 - initial release
// ============================================================================
module cnn_icb_arbiter #(
    parameter int OUTS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        m0_icb_cmd_valid,
    output logic        m0_icb_cmd_ready,
    input  logic [31:0] m0_icb_cmd_addr,
    input  logic        m0_icb_cmd_read,
    input  logic [31:0] m0_icb_cmd_wdata,
    input  logic [3:0]  m0_icb_cmd_wmask,
    output logic        m0_icb_rsp_valid,
    input  logic        m0_icb_rsp_ready,
    output logic [31:0] m0_icb_rsp_rdata,

    input  logic        m1_icb_cmd_valid,
    output logic        m1_icb_cmd_ready,
    input  logic [31:0] m1_icb_cmd_addr,
    input  logic        m1_icb_cmd_read,
    input  logic [31:0] m1_icb_cmd_wdata,
    input  logic [3:0]  m1_icb_cmd_wmask,
    output logic        m1_icb_rsp_valid,
    input  logic        m1_icb_rsp_ready,
    output logic [31:0] m1_icb_rsp_rdata,

    output logic        s_icb_cmd_valid,
    input  logic        s_icb_cmd_ready,
    output logic [31:0] s_icb_cmd_addr,
    output logic        s_icb_cmd_read,
    output logic [31:0] s_icb_cmd_wdata,
    output logic [3:0]  s_icb_cmd_wmask,
    input  logic        s_icb_rsp_valid,
    output logic        s_icb_rsp_ready,
    input  logic [31:0] s_icb_rsp_rdata
);

    localparam int c_PTR_W = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;

    logic                  r_rr_ptr;
    logic                  r_lock;
    logic                  r_lock_id;
    logic [c_PTR_W:0]      r_wr_ptr;
    logic [c_PTR_W:0]      r_rd_ptr;
    logic [OUTS_DEPTH-1:0] r_id_fifo;

    logic w_active;
    logic w_full;
    logic w_empty;
    logic w_head;
    logic w_gnt;
    logic w_gnt_valid;
    logic w_cmd_rdy;
    logic w_push;
    logic w_pop;

    // Reset is active-high; every handshake output is gated while it is held.
    assign w_active = ~rst_n;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]) &&
                     (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]);
    assign w_head  = r_id_fifo[r_rd_ptr[c_PTR_W-1:0]];

    always_comb begin
        w_gnt = 1'b0;
        if (r_lock) begin
            w_gnt = r_lock_id;
        end else if (m0_icb_cmd_valid && m1_icb_cmd_valid) begin
            w_gnt = r_rr_ptr;
        end else if (m1_icb_cmd_valid) begin
            w_gnt = 1'b1;
        end
    end

    assign w_gnt_valid = w_gnt ? m1_icb_cmd_valid : m0_icb_cmd_valid;
    assign w_cmd_rdy   = w_active & s_icb_cmd_ready & ~w_full;

    assign s_icb_cmd_valid  = w_active & w_gnt_valid & ~w_full;
    assign m0_icb_cmd_ready = w_cmd_rdy & ~w_gnt;
    assign m1_icb_cmd_ready = w_cmd_rdy &  w_gnt;

    assign s_icb_cmd_addr  = w_gnt ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
    assign s_icb_cmd_read  = w_gnt ? m1_icb_cmd_read  : m0_icb_cmd_read;
    assign s_icb_cmd_wdata = w_gnt ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
    assign s_icb_cmd_wmask = w_gnt ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;

    // Responses come back in order, so the FIFO head names their owner.
    assign s_icb_rsp_ready  = w_active & ~w_empty &
                              (w_head ? m1_icb_rsp_ready : m0_icb_rsp_ready);
    assign m0_icb_rsp_valid = w_active & s_icb_rsp_valid & ~w_empty & ~w_head;
    assign m1_icb_rsp_valid = w_active & s_icb_rsp_valid & ~w_empty &  w_head;
    assign m0_icb_rsp_rdata = s_icb_rsp_rdata;
    assign m1_icb_rsp_rdata = s_icb_rsp_rdata;

    assign w_push = s_icb_cmd_valid & s_icb_cmd_ready;
    assign w_pop  = s_icb_rsp_valid & s_icb_rsp_ready;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_rr_ptr  <= 1'b0;
            r_lock    <= 1'b0;
            r_lock_id <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_rr_ptr <= ~w_gnt;
                r_lock   <= 1'b0;
            end else if (s_icb_cmd_valid) begin
                // Presented but not accepted: hold the grant until it is.
                r_lock    <= 1'b1;
                r_lock_id <= w_gnt;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // ID storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (!rst_n && w_push) begin
            r_id_fifo[r_wr_ptr[c_PTR_W-1:0]] <= w_gnt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cnn_icb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnn_icb_arbiter
// Purpose  : Directed self-checking bench for cnn_icb_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cnn_icb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_cmd_valid, m0_cmd_ready, m0_cmd_read, m0_rsp_valid, m0_rsp_ready;
    logic [31:0] m0_cmd_addr, m0_cmd_wdata, m0_rsp_rdata;
    logic [3:0]  m0_cmd_wmask;
    logic        m1_cmd_valid, m1_cmd_ready, m1_cmd_read, m1_rsp_valid, m1_rsp_ready;
    logic [31:0] m1_cmd_addr, m1_cmd_wdata, m1_rsp_rdata;
    logic [3:0]  m1_cmd_wmask;
    logic        s_cmd_valid, s_cmd_ready, s_cmd_read, s_rsp_valid, s_rsp_ready;
    logic [31:0] s_cmd_addr, s_cmd_wdata, s_rsp_rdata;
    logic [3:0]  s_cmd_wmask;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cnn_icb_arbiter #(.OUTS_DEPTH(4)) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .m0_icb_cmd_valid (m0_cmd_valid),
        .m0_icb_cmd_ready (m0_cmd_ready),
        .m0_icb_cmd_addr  (m0_cmd_addr),
        .m0_icb_cmd_read  (m0_cmd_read),
        .m0_icb_cmd_wdata (m0_cmd_wdata),
        .m0_icb_cmd_wmask (m0_cmd_wmask),
        .m0_icb_rsp_valid (m0_rsp_valid),
        .m0_icb_rsp_ready (m0_rsp_ready),
        .m0_icb_rsp_rdata (m0_rsp_rdata),
        .m1_icb_cmd_valid (m1_cmd_valid),
        .m1_icb_cmd_ready (m1_cmd_ready),
        .m1_icb_cmd_addr  (m1_cmd_addr),
        .m1_icb_cmd_read  (m1_cmd_read),
        .m1_icb_cmd_wdata (m1_cmd_wdata),
        .m1_icb_cmd_wmask (m1_cmd_wmask),
        .m1_icb_rsp_valid (m1_rsp_valid),
        .m1_icb_rsp_ready (m1_rsp_ready),
        .m1_icb_rsp_rdata (m1_rsp_rdata),
        .s_icb_cmd_valid  (s_cmd_valid),
        .s_icb_cmd_ready  (s_cmd_ready),
        .s_icb_cmd_addr   (s_cmd_addr),
        .s_icb_cmd_read   (s_cmd_read),
        .s_icb_cmd_wdata  (s_cmd_wdata),
        .s_icb_cmd_wmask  (s_cmd_wmask),
        .s_icb_rsp_valid  (s_rsp_valid),
        .s_icb_rsp_ready  (s_rsp_ready),
        .s_icb_rsp_rdata  (s_rsp_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; checks happen 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        m0_cmd_valid = 0; m0_cmd_read = 1; m0_cmd_addr = 32'h100;
        m0_cmd_wdata = 0; m0_cmd_wmask = 4'hF; m0_rsp_ready = 1;
        m1_cmd_valid = 0; m1_cmd_read = 1; m1_cmd_addr = 32'h200;
        m1_cmd_wdata = 0; m1_cmd_wmask = 4'hF; m1_rsp_ready = 1;
        s_cmd_ready = 1; s_rsp_valid = 0; s_rsp_rdata = 0;
    endtask

    logic [31:0] rsp_data [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

    initial begin
        idle();
        rst_n = 1;
        m0_cmd_valid = 1;
        settle();
        check("rst_s_cmd_valid", s_cmd_valid, 0);
        check("rst_m0_cmd_ready", m0_cmd_ready, 0);
        step(); step();
        rst_n = 0;

        // Single write from m0
        m0_cmd_valid = 1; m0_cmd_read = 0; m0_cmd_addr = 32'h1000_0000;
        m0_cmd_wdata = 32'hDEADBEEF; m0_cmd_wmask = 4'hF;
        settle();
        check("wr_s_valid", s_cmd_valid, 1);
        check("wr_s_addr", s_cmd_addr, 32'h1000_0000);
        check("wr_s_wdata", s_cmd_wdata, 32'hDEADBEEF);
        check("wr_s_wmask", {28'd0, s_cmd_wmask}, 32'hF);
        check("wr_s_read", s_cmd_read, 0);
        check("wr_m0_ready", m0_cmd_ready, 1);
        check("wr_m1_ready", m1_cmd_ready, 0);
        step();
        idle();
        s_rsp_valid = 1;
        settle();
        check("wr_m0_rsp", m0_rsp_valid, 1);
        check("wr_m1_rsp", m1_rsp_valid, 0);
        check("wr_s_rsp_ready", s_rsp_ready, 1);
        step();

        // Contention after reset: grants alternate starting with m0
        idle(); rst_n = 1; step(); rst_n = 0;
        m0_cmd_valid = 1; m1_cmd_valid = 1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("cont_s_addr", s_cmd_addr, (i % 2 == 0) ? 32'h100 : 32'h200);
            check("cont_m0_ready", m0_cmd_ready, (i % 2 == 0) ? 1 : 0);
            check("cont_m1_ready", m1_cmd_ready, (i % 2 == 0) ? 0 : 1);
            step();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            s_rsp_valid = 1; s_rsp_rdata = rsp_data[i];
            settle();
            check("cont_m0_rsp", m0_rsp_valid, (i % 2 == 0) ? 1 : 0);
            check("cont_m1_rsp", m1_rsp_valid, (i % 2 == 0) ? 0 : 1);
            check("cont_rdata", (i % 2 == 0) ? m0_rsp_rdata : m1_rsp_rdata, rsp_data[i]);
            step();
        end
        idle();

        // Slave stall: m1 holds grant while m0 joins in the second cycle
        m1_cmd_valid = 1; s_cmd_ready = 0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) m0_cmd_valid = 1;
            settle();
            check("stall_s_valid", s_cmd_valid, 1);
            check("stall_s_addr", s_cmd_addr, 32'h200);
            check("stall_m0_ready", m0_cmd_ready, 0);
            step();
        end
        s_cmd_ready = 1;
        settle();
        check("stall_hs_addr", s_cmd_addr, 32'h200);
        check("stall_hs_m1_ready", m1_cmd_ready, 1);
        step();
        m1_cmd_valid = 0;
        settle();
        check("stall_next_addr", s_cmd_addr, 32'h100);
        check("stall_next_m0_ready", m0_cmd_ready, 1);
        step();
        idle();
        s_rsp_valid = 1;
        settle();
        check("stall_rsp0_m1", m1_rsp_valid, 1);
        step();
        settle();
        check("stall_rsp1_m0", m0_rsp_valid, 1);
        step();
        idle();

        // Outstanding limit: 4 accepted, 5th blocked even with a pop
        m0_cmd_valid = 1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("lim_m0_ready", m0_cmd_ready, 1);
            step();
        end
        s_rsp_valid = 1;
        settle();
        check("lim_full_ready", m0_cmd_ready, 0);
        check("lim_full_s_valid", s_cmd_valid, 0);
        check("lim_full_pop", s_rsp_ready, 1);
        step();
        s_rsp_valid = 0;
        settle();
        check("lim_after_pop_ready", m0_cmd_ready, 1);
        check("lim_after_pop_s_valid", s_cmd_valid, 1);
        step();
        m0_cmd_valid = 0; s_rsp_valid = 1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("lim_drain_m0", m0_rsp_valid, 1);
            step();
        end
        idle();
        s_rsp_valid = 1;
        settle();
        check("lim_empty_rsp_ready", s_rsp_ready, 0);
        step();
        idle();

        // Same-cycle push/pop at count 2: FIFO {m1, m0} -> {m0, m1}
        m1_cmd_valid = 1; settle(); step();
        m1_cmd_valid = 0; m0_cmd_valid = 1; settle(); step();
        m0_cmd_valid = 0; m1_cmd_valid = 1; s_rsp_valid = 1;
        settle();
        check("pp_m1_cmd_ready", m1_cmd_ready, 1);
        check("pp_m1_rsp", m1_rsp_valid, 1);
        check("pp_s_rsp_ready", s_rsp_ready, 1);
        step();
        m1_cmd_valid = 0;
        settle();
        check("pp_head_m0", m0_rsp_valid, 1);
        check("pp_head_not_m1", m1_rsp_valid, 0);
        step();
        settle();
        check("pp_tail_m1", m1_rsp_valid, 1);
        step();
        settle();
        check("pp_empty", s_rsp_ready, 0);
        idle();
        step();

        // Reset mid-operation with 3 outstanding; rr_ptr left pointing at m1
        m0_cmd_valid = 1;
        for (int i = 0; i < 3; i++) begin settle(); step(); end
        rst_n = 1; m1_cmd_valid = 1; s_rsp_valid = 1;
        settle();
        check("mid_rst_s_valid", s_cmd_valid, 0);
        check("mid_rst_m0_ready", m0_cmd_ready, 0);
        check("mid_rst_m1_ready", m1_cmd_ready, 0);
        check("mid_rst_s_rsp_ready", s_rsp_ready, 0);
        check("mid_rst_m0_rsp", m0_rsp_valid, 0);
        step();
        rst_n = 0; m0_cmd_valid = 0; m1_cmd_valid = 0;
        settle();
        check("stray_s_rsp_ready", s_rsp_ready, 0);
        check("stray_m0_rsp", m0_rsp_valid, 0);
        step();
        s_rsp_valid = 0; m0_cmd_valid = 1; m1_cmd_valid = 1;
        settle();
        check("post_rst_addr", s_cmd_addr, 32'h100);
        check("post_rst_m0_ready", m0_cmd_ready, 1);
        step();
        settle();
        check("post_rst_next_addr", s_cmd_addr, 32'h200);
        step();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cnn_icb_arbiter.md
# cnn_icb_arbiter

Two-master, one-slave ICB arbiter that shares the data SRAM port between the E203 CPU data path (master 0) and the CNN core's master interface (master 1, the `cnn_icb_*` bus of the CNN top). It passes commands through to the slave with zero added latency and arbitrates round-robin. It tracks up to OUTS_DEPTH outstanding transactions in an ID FIFO so that in-order slave responses are routed back to the correct master.

## Interface
- OUTS_DEPTH, 4, max outstanding accepted commands awaiting response; power of 2, ≥2
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous reset, active-high (asserted = 1; name kept for codebase consistency)
- m0_icb_cmd_valid / m1_icb_cmd_valid  in  1  master command valid
- m0_icb_cmd_ready / m1_icb_cmd_ready  out  1  master command ready
- m0_icb_cmd_addr / m1_icb_cmd_addr  in  32  byte address
- m0_icb_cmd_read / m1_icb_cmd_read  in  1  1 = read, 0 = write
- m0_icb_cmd_wdata / m1_icb_cmd_wdata  in  32  write data
- m0_icb_cmd_wmask / m1_icb_cmd_wmask  in  4  byte-enable
- m0_icb_rsp_valid / m1_icb_rsp_valid  out  1  response valid
- m0_icb_rsp_ready / m1_icb_rsp_ready  in  1  response ready
- m0_icb_rsp_rdata / m1_icb_rsp_rdata  out  32  read data
- s_icb_cmd_valid  out  1  slave command valid
- s_icb_cmd_ready  in  1  slave command ready
- s_icb_cmd_addr / s_icb_cmd_read / s_icb_cmd_wdata / s_icb_cmd_wmask  out  32/1/32/4  muxed command fields
- s_icb_rsp_valid  in  1  slave response valid
- s_icb_rsp_ready  out  1  slave response ready
- s_icb_rsp_rdata  in  32  slave read data

## Operation
- State: `rr_ptr` (priority master, 0/1), `lock` + `lock_id` (grant held), ID FIFO (OUTS_DEPTH × 1 bit, wr/rd pointers with wrap bit).
- Grant selection (comb): if `lock`, grant = `lock_id`. Else if only one master is valid, grant goes to it. If both are valid, grant = `rr_ptr`.
- s_icb_cmd_valid = granted master's valid AND NOT fifo_full. The command fields mux from the granted master. When no master is granted, the fields are driven from m0 with valid 0.
- Granted master's cmd_ready = s_icb_cmd_ready AND NOT fifo_full. The non-granted master's cmd_ready = 0.
- Lock: if s_icb_cmd_valid = 1 and s_icb_cmd_ready = 0, set `lock`=1, `lock_id`=grant next cycle. Clear on the slave cmd handshake. This keeps the presented command stable per ICB rules.
- On slave cmd handshake: push grant ID into the FIFO, set `rr_ptr` = ~grant.
- Response routing: head = FIFO front ID. mX_icb_rsp_valid = s_icb_rsp_valid AND NOT fifo_empty AND head==X. Both masters receive rdata = s_icb_rsp_rdata. s_icb_rsp_ready = head master's rsp_ready AND NOT fifo_empty.
- On slave rsp handshake: pop the FIFO.
- Push and pop in the same cycle are both allowed; the count is unchanged.
- When full, push is blocked even if a pop occurs in the same cycle (ready depends only on registered full).
- Empty FIFO with s_icb_rsp_valid=1 is a protocol violation: s_icb_rsp_ready=0, nothing routed, no state change.
- FIFO pointers wrap modulo OUTS_DEPTH. Full = indices equal and wrap bits differ. Empty = pointers equal.

## Timing
- Command and response paths are combinational; there are 0 cycles of added latency.
- `rr_ptr`, `lock` and FIFO update on the clock edge after the handshake.
- Reset (synchronous, rst_n=1 at edge):
  - `rr_ptr`=0, `lock`=0, FIFO empty.
  - All ready/valid outputs evaluate to 0 while reset is held: gate with rst_n.
  - Reset mid-operation discards outstanding IDs. Any later slave responses hit the empty-FIFO rule.
- Throughput: one command per cycle while not full; one response per cycle.

## Test plan
- **Single write:** m0 writes addr 0x1000_0000, wdata 0xDEADBEEF, wmask 0xF, with slave ready. Then:
  - s_icb shows the same fields in the same cycle, and m0_cmd_ready=1.
  - The response 1 cycle later appears only on m0_rsp_valid.
- **Simultaneous contention after reset:** both masters are valid every cycle and the slave is always ready.
  - Grants alternate m0, m1, m0, m1.
  - Responses return with rdata 0x11, 0x22, 0x33, 0x44 to m0, m1, m0, m1 respectively.
- **Slave stall lock:** m1 is granted and s_cmd_ready=0 for 3 cycles, while m0 raises valid in cycle 2.
  - The grant stays on m1 and the s_icb addr stays constant.
  - m0 is granted on the cycle after m1's handshake.
- **Outstanding limit:** with OUTS_DEPTH=4, the slave accepts 4 commands and withholds responses.
  - The 5th command sees cmd_ready=0 and s_cmd_valid=0.
  - After one response is popped, the 5th is accepted on the next cycle.
- **Same-cycle push/pop:** with the FIFO at count 2, a command handshake and a response handshake occur in the same cycle.
  - The count stays 2 and the head advances to the correct ID.
- **Reset mid-operation:** assert rst_n=1 with 3 outstanding. Then:
  - All valids and readys are 0.
  - A subsequent stray s_rsp_valid gets s_rsp_ready=0.
  - The next command is granted to m0 first.
